// File: rtl/vregfile_pkg.sv
// Shared definitions for the multi-port vector register file.
//   NREGS_DEF / NLANES_DEF / W_DEF : default geometry (registers, lanes, lane width)
//   ld_state_e                      : serial-load controller states
//   clog2_min1()                    : index width that never collapses to zero bits
package vregfile_pkg;
  localparam int NREGS_DEF  = 16;
  localparam int NLANES_DEF = 5;
  localparam int W_DEF      = 32;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vreg_load_fsm.sv
// Element-serial load controller for the vector register file.
// Captures the target register on ld_start_i, then accepts one element per
// ld_valid_i && ld_ready_o beat, lane 0 upward, pulsing ld_done_o after the
// last lane. The full-write port always wins: ld_ready_o drops while we_i=1.
//   clk, reset (async, active-high)
//   we_i                 : full-write port active this cycle (stalls loading)
//   ld_start_i, ld_vd_i  : begin a load into register ld_vd_i (ignored while loading)
//   ld_valid_i           : element beat offered
//   ld_ready_o, ld_busy_o, ld_done_o : handshake / status
//   lwe_o, lane_o, lreg_o : element write strobe, lane index, target register
module vreg_load_fsm
  import vregfile_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int AW     = 4,
  parameter int LW     = clog2_min1(NLANES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic          ld_start_i,
  input  logic [AW-1:0] ld_vd_i,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  output logic          ld_busy_o,
  output logic          ld_done_o,
  output logic          lwe_o,
  output logic [LW-1:0] lane_o,
  output logic [AW-1:0] lreg_o
);
  ld_state_e     state_q;
  logic [LW-1:0] cnt_q;
  logic [AW-1:0] vd_q;
  logic          done_q;

  assign ld_busy_o  = (state_q == LD_LOAD);
  assign ld_ready_o = ld_busy_o & ~we_i;
  assign lwe_o      = ld_ready_o & ld_valid_i;
  assign lane_o     = cnt_q;
  assign lreg_o     = vd_q;
  assign ld_done_o  = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      vd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LD_IDLE: begin
          if (ld_start_i) begin
            vd_q    <= ld_vd_i;
            cnt_q   <= '0;
            state_q <= LD_LOAD;
          end
        end
        LD_LOAD: begin
          // ld_start_i is deliberately not looked at here
          if (lwe_o) begin
            if (cnt_q == LW'(NLANES - 1)) begin
              cnt_q   <= '0;
              state_q <= LD_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + LW'(1);
            end
          end
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vector_regfile_mp.sv
// Vector register file: NREGS registers of NLANES x W-bit elements.
// One masked full-vector write port, one element-serial load port, two
// combinational read ports with write-first bypass. Addresses >= NREGS are
// ignored on write and read back as zero.
//   clk, reset (async, active-high)
//   we, wmask, vd, wd    : masked full write; lane i on wd[i*W +: W]
//   va1/vr1, va2/vr2     : read ports, packed like wd
//   ld_start, ld_vd      : start serial load into ld_vd
//   ld_valid, ld_data, ld_ready : element handshake
//   ld_busy, ld_done     : load status / one-cycle completion pulse
module vector_regfile_mp
  import vregfile_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NLANES = NLANES_DEF,
  parameter  int W      = W_DEF,
  localparam int AW     = clog2_min1(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [NLANES-1:0]   wmask,
  input  logic [AW-1:0]       vd,
  input  logic [NLANES*W-1:0] wd,
  input  logic [AW-1:0]       va1,
  input  logic [AW-1:0]       va2,
  output logic [NLANES*W-1:0] vr1,
  output logic [NLANES*W-1:0] vr2,
  input  logic                ld_start,
  input  logic [AW-1:0]       ld_vd,
  input  logic                ld_valid,
  input  logic [W-1:0]        ld_data,
  output logic                ld_ready,
  output logic                ld_busy,
  output logic                ld_done
);
  localparam int LW = clog2_min1(NLANES);

  logic [W-1:0]  mem_q [NREGS][NLANES];
  logic          lwe;
  logic [LW-1:0] lane;
  logic [AW-1:0] lreg;

  vreg_load_fsm #(.NLANES(NLANES), .AW(AW)) u_ld (
    .clk        (clk),
    .reset      (reset),
    .we_i       (we),
    .ld_start_i (ld_start),
    .ld_vd_i    (ld_vd),
    .ld_valid_i (ld_valid),
    .ld_ready_o (ld_ready),
    .ld_busy_o  (ld_busy),
    .ld_done_o  (ld_done),
    .lwe_o      (lwe),
    .lane_o     (lane),
    .lreg_o     (lreg)
  );

  logic wr_ok, ld_ok;
  assign wr_ok = int'(vd) < NREGS;
  assign ld_ok = int'(lreg) < NREGS;

  // we and lwe are mutually exclusive (ld_ready is gated by we)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < NLANES; l++)
          mem_q[r][l] <= '0;
    end else begin
      if (we && wr_ok)
        for (int l = 0; l < NLANES; l++)
          if (wmask[l]) mem_q[vd][l] <= wd[l*W +: W];
      if (lwe && ld_ok)
        mem_q[lreg][lane] <= ld_data;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]       a;
    logic [NLANES*W-1:0] r;
    assign a = (p == 0) ? va1 : va2;
    always_comb begin
      r = '0;
      if (int'(a) < NREGS) begin
        for (int l = 0; l < NLANES; l++) begin
          r[l*W +: W] = mem_q[a][l];
          if (we && vd == a && wmask[l])              r[l*W +: W] = wd[l*W +: W];
          if (lwe && lreg == a && int'(lane) == l)    r[l*W +: W] = ld_data;
        end
      end
    end
  end

  assign vr1 = g_rd[0].r;
  assign vr2 = g_rd[1].r;
endmodule
